// File: rtl/fcache_pkg.sv
// fcache_pkg -- shared constants, types and address helpers for the fcache
// line cache.
//   ADDR_W  : line-address width
//   DATA_W  : line data width
//   INDEX_W : index bits (2**INDEX_W lines); TAG_W = ADDR_W - INDEX_W
// The optional read/write forwarding path is enabled by FCACHE_FWD_EN.
package fcache_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 256;
  localparam int INDEX_W   = 8;
  localparam int TAG_W     = ADDR_W - INDEX_W;
  localparam int NUM_LINES = 1 << INDEX_W;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [DATA_W-1:0]  line_t;
  typedef logic [INDEX_W-1:0] index_t;
  typedef logic [TAG_W-1:0]   tag_t;

  // One tag/valid entry as seen by the lookup compare.
  typedef struct packed {
    logic valid;
    tag_t tag;
  } tag_entry_t;

  function automatic index_t addr_index(input addr_t a);
    return a[INDEX_W-1:0];
  endfunction

  function automatic tag_t addr_tag(input addr_t a);
    return a[ADDR_W-1:INDEX_W];
  endfunction

endpackage

// File: rtl/fcache_if.sv
// fcache_if -- request/response bundle between a client and the fcache.
//   read  : level-sensitive read request (combinational lookup)
//   write : write request, captured on the rising clock edge
//   addr  : line address (index in the low bits, tag in the high bits)
//   wData : line to be written
//   rData : line returned on a hit, zero otherwise
//   hit   : read hit indicator
// Modports: master (client side), slave (cache side).
interface fcache_if;
  import fcache_pkg::*;

  logic  read;
  logic  write;
  addr_t addr;
  line_t wData;
  line_t rData;
  logic  hit;

  modport master (output read, output write, output addr, output wData,
                  input  rData, input  hit);
  modport slave  (input  read, input  write, input  addr, input  wData,
                  output rData, output hit);
endinterface

// File: rtl/fcache_tag_array.sv
// fcache_tag_array -- valid/tag storage and hit compare for the fcache.
//   clk, rst_n : clock; asynchronous active-low reset clears every valid bit
//   we         : write the entry at index with tag and mark it valid
//   lookup     : read request; hit is forced low when it is 0
//   index, tag : split line address
//   hit        : lookup & valid[index] & (stored tag == tag)
// Tag storage is deliberately not reset; valid alone gates visibility.
module fcache_tag_array
  import fcache_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   we,
  input  logic   lookup,
  input  index_t index,
  input  tag_t   tag,
  output logic   hit
);

  logic [NUM_LINES-1:0] valid;
  tag_t                 tags [NUM_LINES];
  tag_entry_t           entry;

  // Valid bits: async clear on reset, set by a write to the indexed line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (we) begin
      valid[index] <= 1'b1;
    end
  end

  // Tag storage; a write always replaces the tag, evicting any alias.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[index] <= tag;
    end
  end

  // Lookup of the indexed entry and tag compare.
  always_comb begin
    entry.valid = valid[index];
    entry.tag   = tags[index];
    if (lookup && entry.valid && (entry.tag == tag)) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/fcache.sv
// fcache -- direct-mapped, write-allocate line cache.
//   clk   : system clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset (clears valid bits only)
//   bus   : fcache_if.slave (read, write, addr, wData -> rData, hit)
// Reads are combinational with zero latency; writes land on the edge and
// always overwrite the indexed line. With FCACHE_FWD_EN defined, a read and
// write in the same cycle return wData before the edge (the bus carries a
// single address, so both requests always name the same line).
module fcache
  import fcache_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  fcache_if.slave  bus
);

  line_t  data_mem [NUM_LINES];
  index_t index;
  tag_t   tag;
  logic   tag_hit;
  logic   fwd;

  // Address split into index and tag.
  always_comb begin
    index = addr_index(bus.addr);
    tag   = addr_tag(bus.addr);
  end

  fcache_tag_array u_tags (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (bus.write),
    .lookup (bus.read),
    .index  (index),
    .tag    (tag),
    .hit    (tag_hit)
  );

  // Data storage; not reset, content only visible once its valid bit is set.
  always_ff @(posedge clk) begin
    if (bus.write) begin
      data_mem[index] <= bus.wData;
    end
  end

  // Same-cycle forwarding select (disabled in the default build).
  always_comb begin
`ifdef FCACHE_FWD_EN
    fwd = rst_n & bus.read & bus.write;
`else
    fwd = 1'b0;
`endif
  end

  // Read response: forwarded line, stored line on a hit, or zeros.
  always_comb begin
    if (fwd) begin
      bus.hit   = 1'b1;
      bus.rData = bus.wData;
    end else if (tag_hit) begin
      bus.hit   = 1'b1;
      bus.rData = data_mem[index];
    end else begin
      bus.hit   = 1'b0;
      bus.rData = '0;
    end
  end

endmodule

// File: tb/tb_fcache.sv
// tb_fcache -- randomized scoreboard bench for fcache. The stimulus process
// computes each read's expected response from a line-level model of the
// cache and queues it; a negedge monitor pops and compares.
module tb_fcache;
  import fcache_pkg::*;

  typedef struct {
    logic  hit;
    line_t data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  // Reference model: per line the stored tag, data and a valid flag.
  line_t m_data  [NUM_LINES];
  tag_t  m_tag   [NUM_LINES];
  bit    m_valid [NUM_LINES];

  fcache_if bus ();

  fcache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic line_t rand_line();
    line_t v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One bus cycle: drive just after the edge, queue expectation, update model.
  task automatic step(input bit rd, input bit wr, input addr_t a,
                      input line_t d, input bit rn);
    exp_t e;
    int   idx;
    @(posedge clk);
    #1;
    rst_n     = rn;
    bus.read  = rd;
    bus.write = wr;
    bus.addr  = a;
    bus.wData = d;
    idx = int'(a[INDEX_W-1:0]);
    if (!rn) begin
      for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;
    end
    e.hit  = rd && rn && m_valid[idx] && (m_tag[idx] == a[ADDR_W-1:INDEX_W]);
    e.data = e.hit ? m_data[idx] : '0;
`ifdef FCACHE_FWD_EN
    if (rd && wr && rn) begin
      e.hit  = 1'b1;
      e.data = d;
    end
`endif
    if (rd) exp_q.push_back(e);
    // The edge that captures this write only takes effect with reset released.
    if (wr && rn) begin
      m_data[idx]  = d;
      m_tag[idx]   = a[ADDR_W-1:INDEX_W];
      m_valid[idx] = 1'b1;
    end
  endtask

  // Monitor: compare every presented read against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.read === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read addr=%h: no queued expectation", bus.addr);
      end else begin
        e = exp_q.pop_front();
        if (bus.hit !== e.hit) begin
          failures++;
          $display("FAIL hit addr=%h got=%b want=%b", bus.addr, bus.hit, e.hit);
        end
        checks++;
        if (bus.rData !== e.data) begin
          failures++;
          $display("FAIL rdata addr=%h got=%h want=%h", bus.addr, bus.rData, e.data);
        end
      end
    end else begin
      checks++;
      if (bus.hit !== 1'b0 || bus.rData !== '0) begin
        failures++;
        $display("FAIL idle_out hit=%b rdata=%h want 0/0", bus.hit, bus.rData);
      end
    end
  end

  initial begin
    line_t big;
    line_t d;
    addr_t a;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    bus.addr  = '0;
    bus.wData = '0;
    for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;

    // Reset held, including a write and read while low, then a read miss.
    step(1'b1, 1'b1, 16'h0000, 256'd5, 1'b0);
    step(1'b0, 1'b0, 16'h0000, '0, 1'b1);
    step(1'b1, 1'b0, 16'h0000, '0, 1'b1);

    // Bit-exact wide values: 2**255 down to 2**255-4.
    big = 256'd1 << 255;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 16'h0012, big - line_t'(k), 1'b1);
      step(1'b1, 1'b0, 16'h0012, '0, 1'b1);
    end

    // Address sample sweep: 5 write/read pairs with decrementing data each.
    for (int n = 0; n < 64; n++) begin
      a = addr_t'($urandom);
      d = rand_line();
      for (int j = 0; j < 5; j++) begin
        step(1'b0, 1'b1, a, d - line_t'(j), 1'b1);
        step(1'b1, 1'b0, a, '0, 1'b1);
      end
    end

    // Aliasing on one index.
    step(1'b0, 1'b1, 16'h0105, 256'hA, 1'b1);
    step(1'b0, 1'b1, 16'h0205, 256'hB, 1'b1);
    step(1'b1, 1'b0, 16'h0105, '0, 1'b1);
    step(1'b1, 1'b0, 16'h0205, '0, 1'b1);

    // Reset after a write: line must miss until rewritten.
    step(1'b0, 1'b1, 16'h0033, 256'hC, 1'b1);
    step(1'b1, 1'b0, 16'h0033, '0, 1'b1);
    step(1'b0, 1'b0, 16'h0033, '0, 1'b0);
    step(1'b1, 1'b0, 16'h0033, '0, 1'b1);

    // Simultaneous read and write on one line, then read after the edge.
    step(1'b1, 1'b1, 16'h0044, 256'hD, 1'b1);
    step(1'b1, 1'b0, 16'h0044, '0, 1'b1);
    step(1'b1, 1'b1, 16'h0044, 256'hE, 1'b1);
    step(1'b1, 1'b0, 16'h0044, '0, 1'b1);

    // Random traffic over a small address pool to exercise hits and aliases.
    for (int n = 0; n < 600; n++) begin
      a = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 7))};
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, rand_line(),
           ($urandom_range(0, 99) != 0));
    end

    step(1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
